angular_filter_accumulator: RTL and testbench
=============================================

// Module: angular_filter_accumulator
// PURPOSE
//  Consumer of the MCM coefficient-product stage in the intra angular predictor.
//  Accepts one filter tap per beat: LANES signed products coef*refSample.
//  Accumulates NTAPS beats per lane, rounds, right-shifts and clips to sample
//  range, then emits LANES predicted samples over a valid/ready handshake.
// PARAMETERS
//  LANES    8   parallel prediction lanes (one per MCM output)
//  PROD_W   16  signed product width per lane
//  ACC_W    18  signed accumulator width per lane
//  NTAPS    4   taps (beats) per output group
//  SHIFT    6   normalisation shift (coefficients sum to 64)
//  BITDEPTH 8   output sample width
// PORTS
//  clk         in   1                 rising-edge clock
//  rst_n       in   1                 asynchronous active-low reset
//  flush       in   1                 sync clear: discards partial group and pending output
//  in_valid    in   1                 beat present
//  in_ready    out  1                 beat accepted when in_valid & in_ready
//  in_prod     in   LANES*PROD_W      signed products, lane k at [k*PROD_W +: PROD_W]
//  out_valid   out  1                 out_sample holds a finished group
//  out_ready   in   1                 downstream accepts when out_valid & out_ready
//  out_sample  out  LANES*BITDEPTH    unsigned samples, lane k at [k*BITDEPTH +: BITDEPTH]
// BEHAVIOUR
//  Reset: state=ACC, tap_cnt=0, acc=0, out_valid=0, out_sample=0, in_ready=1.
//  States: ACC (collecting beats) and HOLD (out_valid=1, result waiting).
//  in_ready = (state==ACC) | out_ready.
//  Beat accept with tap_cnt==0: acc_k <= sext(prod_k) (load, not add).
//  Beat accept with 0<tap_cnt<NTAPS-1: acc_k <= acc_k + sext(prod_k); tap_cnt++.
//  Beat accept with tap_cnt==NTAPS-1: s_k = acc_k + prod_k; r_k = (s_k + 2^(SHIFT-1)) >>> SHIFT
//   (arithmetic, floor); out_sample_k <= clip(r_k, 0, 2^BITDEPTH-1); out_valid <= 1;
//   tap_cnt <= 0; state -> HOLD. Latency: result visible one cycle after last beat.
//  HOLD & out_ready & no beat: out_valid <= 0, state -> ACC; out_sample retained.
//  HOLD & out_ready & beat accepted: output consumed and beat processed in the same
//   cycle (first beat of next group; full throughput of one group per NTAPS cycles).
//  HOLD & !out_ready: in_ready=0, out_sample/out_valid stable, no beat accepted.
//  flush (priority over all else): tap_cnt<=0, out_valid<=0, state->ACC; beat in the
//   same cycle ignored; acc value is don't-care (next beat loads it).
//  Reset asserted mid-group: all state returns to reset values immediately.
//  Widths: ACC_W must hold NTAPS*max|prod| + rounding; no saturation inside acc.
// STRUCTURE
//  Shared package: LANES, PROD_W, ACC_W, SHIFT, BITDEPTH defaults; state enum
//   {ACC, HOLD}; clip-to-bitdepth function.
//  One sub-module: afa_round_clip (combinational per-lane round+shift+clip),
//   instantiated LANES times; FSM, tap counter and accumulators in the top.
// TESTING
//  1 All lanes prod=1600 for 4 beats, out_ready=1 -> out_valid cycle after beat 4,
//    every sample=100 ((6400+32)>>6).
//  2 Lane0 beats -300 x4 -> sample 0 (neg clip); lane1 5000 x4 -> 255 (pos clip);
//    lane2 beats {31,0,0,0} -> 0; lane3 {32,0,0,0} -> 1 (rounding boundary).
//  3 out_ready=0 after group done -> in_ready=0, 5th beat held, out_sample stable
//    10 cycles; raise out_ready -> output consumed and 5th beat accepted same cycle.
//  4 Continuous in_valid, out_ready=1, 3 groups {1600,3200,640 per beat} -> outputs
//    100,200,40 exactly every 4 cycles, no lost or duplicated beat.
//  5 flush after beat 2 then 4 beats of 1600 -> single output 100 (partial dropped);
//    flush while HOLD -> out_valid=0 next cycle.
//  6 rst_n low after beat 3 -> out_valid=0, in_ready=1 asynchronously; next 4 beats
//    of 64 -> sample 4.

Source files
------------

// File: rtl/angular_filter_accumulator_pkg.sv
// Shared constants, FSM state type and the sample clip helper for the
// angular-prediction filter accumulator.
package angular_filter_accumulator_pkg;

  localparam int LANES    = 8;
  localparam int PROD_W   = 16;
  localparam int ACC_W    = 18;
  localparam int NTAPS    = 4;
  localparam int SHIFT    = 6;
  localparam int BITDEPTH = 8;
  localparam int CNT_W    = $clog2(NTAPS);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Clip a rounded, one-bit-widened accumulator value into [0, 2^BITDEPTH-1].
  function automatic logic [BITDEPTH-1:0] clip_sample(input logic signed [ACC_W:0] r);
    logic signed [ACC_W:0] max_v;
    max_v = (ACC_W+1)'((1 << BITDEPTH) - 1);
    if (r[ACC_W])       return '0;
    else if (r > max_v) return '1;
    else                return r[BITDEPTH-1:0];
  endfunction

endpackage

// File: rtl/afa_round_clip.sv
// Per-lane datapath: accumulate one product, then round, shift and clip the sum
// to a sample. The sum is shared with the top for the middle taps.
module afa_round_clip
  import angular_filter_accumulator_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [ACC_W-1:0]  sum,
  output logic [BITDEPTH-1:0]      sample
);

  localparam int ROUND = 1 << (SHIFT - 1);

  logic signed [ACC_W:0] rounded;
  logic signed [ACC_W:0] shifted;

  // One extra bit so the rounding offset cannot wrap a near-full accumulator.
  assign sum     = acc + ACC_W'(prod);
  assign rounded = (ACC_W+1)'(sum) + (ACC_W+1)'(ROUND);
  assign shifted = rounded >>> SHIFT;
  assign sample  = clip_sample(shifted);

endmodule

// File: rtl/angular_filter_accumulator.sv
// Collects NTAPS product beats per lane, normalises each lane to a sample and
// presents the group over a valid/ready handshake; holds the result until taken.
module angular_filter_accumulator
  import angular_filter_accumulator_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*PROD_W-1:0]     in_prod,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*BITDEPTH-1:0]   out_sample
);

  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NTAPS - 1);

  state_t                    state;
  state_t                    state_next;
  logic [CNT_W-1:0]          tap_cnt;
  logic signed [PROD_W-1:0]  prod   [LANES];
  logic signed [ACC_W-1:0]   acc    [LANES];
  logic signed [ACC_W-1:0]   sum    [LANES];
  logic [BITDEPTH-1:0]       result [LANES];
  logic                      beat;
  logic                      last_beat;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign prod[k] = in_prod[k*PROD_W +: PROD_W];

    afa_round_clip u_round_clip (
      .acc    (acc[k]),
      .prod   (prod[k]),
      .sum    (sum[k]),
      .sample (result[k])
    );
  end

  // A waiting result blocks input only while downstream stalls, so the next
  // group's first beat can overlap with the handoff.
  assign in_ready  = (state == ACC) | out_ready;
  assign out_valid = (state == HOLD);
  assign beat      = in_valid & in_ready;
  assign last_beat = beat & (tap_cnt == LAST_TAP);

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    if (flush)                            state_next = ACC;
    else if (last_beat)                   state_next = HOLD;
    else if (state == HOLD && out_ready)  state_next = ACC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) state <= ACC;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt    <= '0;
      out_sample <= '0;
      // NOTE: the lane accumulators are a small register array, reset like any flop.
      for (int k = 0; k < LANES; k++) acc[k] <= '0;
    end else if (flush) begin
      tap_cnt <= '0;
    end else if (beat) begin
      if (tap_cnt == LAST_TAP) begin
        tap_cnt <= '0;
        for (int k = 0; k < LANES; k++) out_sample[k*BITDEPTH +: BITDEPTH] <= result[k];
      end else begin
        tap_cnt <= tap_cnt + CNT_W'(1);
        // First tap loads rather than adds, so no clear is needed between groups.
        for (int k = 0; k < LANES; k++) acc[k] <= (tap_cnt == '0) ? ACC_W'(prod[k]) : sum[k];
      end
    end
  end

endmodule

// File: tb/tb_angular_filter_accumulator.sv
// Directed bench for angular_filter_accumulator with a queue scoreboard fed by a
// per-lane reference model of accumulate/round/shift/clip.
module tb_angular_filter_accumulator;
  import angular_filter_accumulator_pkg::*;

  typedef int lane_arr_t [LANES];
  typedef logic [LANES*BITDEPTH-1:0] sample_vec_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*PROD_W-1:0]   in_prod;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*BITDEPTH-1:0] out_sample;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sample_vec_t exp_q   [$];
  int          pop_cyc [$];
  int          model_sum [LANES];
  int          model_tap = 0;

  angular_filter_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_prod    (in_prod),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BITDEPTH-1:0] ref_sample(input int s);
    int r;
    r = (s + (1 << (SHIFT - 1))) >>> SHIFT;
    if (r < 0)                  return '0;
    if (r > (1 << BITDEPTH) - 1) return '1;
    return r[BITDEPTH-1:0];
  endfunction

  function automatic lane_arr_t all_lanes(input int v);
    lane_arr_t a;
    for (int k = 0; k < LANES; k++) a[k] = v;
    return a;
  endfunction

  // Drive one beat and wait (bounded) for acceptance; updates the reference model.
  task automatic send_beat(input lane_arr_t p, output int waited);
    bit          accepted;
    sample_vec_t v;
    in_valid = 1'b1;
    for (int k = 0; k < LANES; k++) in_prod[k*PROD_W +: PROD_W] = PROD_W'(p[k]);
    waited   = 0;
    accepted = 1'b0;
    while (!accepted && waited < 50) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
      if (!accepted) waited++;
    end
    check("beat_accepted", accepted, 1);
    if (accepted) begin
      for (int k = 0; k < LANES; k++)
        model_sum[k] = (model_tap == 0) ? p[k] : model_sum[k] + p[k];
      model_tap++;
      if (model_tap == NTAPS) begin
        for (int k = 0; k < LANES; k++) v[k*BITDEPTH +: BITDEPTH] = ref_sample(model_sum[k]);
        exp_q.push_back(v);
        model_tap = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_flush(input int junk);
    flush    = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < LANES; k++) in_prod[k*PROD_W +: PROD_W] = PROD_W'(junk);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    model_tap = 0;
  endtask

  // Scoreboard: every completed handshake must match the oldest expected group.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      check("output_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("out_sample", out_sample, exp_q.pop_front());
      pop_cyc.push_back(cyc);
    end
  end

  initial begin
    int        w;
    int        n_pop;
    lane_arr_t t2 [4];
    int        t4 [3];

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_prod = '0;
    #12;
    check("reset_out_valid",  out_valid,  0);
    check("reset_in_ready",   in_ready,   1);
    check("reset_out_sample", out_sample, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;

    // 1: all lanes 1600 x4 -> 100, visible the cycle after the last beat
    for (int b = 0; b < 4; b++) begin
      send_beat(all_lanes(1600), w);
      if (b == 2) check("t1_not_early", out_valid, 0);
    end
    check("t1_latency", out_valid, 1);
    check("t1_value", out_sample, {LANES{8'd100}});
    idle(2);
    check("t1_consumed", out_valid, 0);

    // 2: negative clip, positive clip, rounding boundary
    t2[0] = '{-300, 5000, 31, 32, 100, 1000, -31, 4080};
    t2[1] = '{-300, 5000,  0,  0, -50, 1000,   0, 4080};
    t2[2] = '{-300, 5000,  0,  0,  10, 1000,   0, 4080};
    t2[3] = '{-300, 5000,  0,  0,   0, 1000,   0, 4080};
    for (int b = 0; b < 4; b++) send_beat(t2[b], w);
    check("t2_neg_clip",  out_sample[0*BITDEPTH +: BITDEPTH], 0);
    check("t2_pos_clip",  out_sample[1*BITDEPTH +: BITDEPTH], 255);
    check("t2_round_31",  out_sample[2*BITDEPTH +: BITDEPTH], 0);
    check("t2_round_32",  out_sample[3*BITDEPTH +: BITDEPTH], 1);
    idle(2);

    // 3: downstream stall holds result and blocks the next beat
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) send_beat(all_lanes(1600), w);
    in_valid = 1'b1;
    for (int k = 0; k < LANES; k++) in_prod[k*PROD_W +: PROD_W] = PROD_W'(640);
    repeat (10) begin
      @(negedge clk);
      check("t3_in_ready_low", in_ready, 0);
      check("t3_hold_valid", out_valid, 1);
      check("t3_stable", out_sample, {LANES{8'd100}});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_beat(all_lanes(640), w);
    check("t3_same_cycle", w, 0);
    check("t3_drained", exp_q.size(), 0);
    check("t3_back_to_acc", out_valid, 0);
    for (int b = 0; b < 3; b++) send_beat(all_lanes(640), w);
    idle(2);

    // 4: back-to-back groups at full throughput
    t4 = '{1600, 3200, 640};
    n_pop = pop_cyc.size();
    for (int g = 0; g < 3; g++)
      for (int b = 0; b < 4; b++) begin
        send_beat(all_lanes(t4[g]), w);
        check("t4_no_stall", w, 0);
      end
    idle(2);
    check("t4_pop_count", pop_cyc.size() - n_pop, 3);
    if (pop_cyc.size() - n_pop == 3) begin
      check("t4_spacing_a", pop_cyc[n_pop+1] - pop_cyc[n_pop],   4);
      check("t4_spacing_b", pop_cyc[n_pop+2] - pop_cyc[n_pop+1], 4);
    end

    // 5: flush drops a partial group, and drops a held result
    n_pop = pop_cyc.size();
    send_beat(all_lanes(5000), w);
    send_beat(all_lanes(5000), w);
    pulse_flush(999);
    for (int b = 0; b < 4; b++) send_beat(all_lanes(1600), w);
    idle(2);
    check("t5_single_output", pop_cyc.size() - n_pop, 1);
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) send_beat(all_lanes(1600), w);
    check("t5_hold_before_flush", out_valid, 1);
    pulse_flush(0);
    check("t5_flush_clears_valid", out_valid, 0);
    check("t5_flush_in_ready", in_ready, 1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    idle(1);
    check("t5_stays_clear", out_valid, 0);

    // 6: asynchronous reset mid-group, then a clean group of 64s -> 4
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) send_beat(all_lanes(1600), w);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_out_valid",  out_valid,  0);
    check("t6_async_in_ready",   in_ready,   1);
    check("t6_async_out_sample", out_sample, 0);
    model_tap = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int b = 0; b < 4; b++) send_beat(all_lanes(64), w);
    check("t6_value", out_sample, {LANES{8'd4}});
    idle(2);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
